// File: rtl/sig_pulse_arbiter.sv
// Round-robin arbiter that owns the shared `sig` line and drives a pulse of each winner's programmed length.
// Optional SIG_PULSE_ABORT_EN adds `abort`/`aborted` for early termination of the pulse being driven.
module sig_pulse_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
`ifdef SIG_PULSE_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     sig,
  output logic                     busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [LEN_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;

  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_sig;
  logic               r_busy;
  logic               r_aborted;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_any;
  logic [PTR_W-1:0]   w_pick;
  logic [LEN_W-1:0]   w_pick_len;
  logic [PTR_W-1:0]   w_owner_next;
  logic [NUM_REQ-1:0] w_gnt_next;
  logic [NUM_REQ-1:0] w_done_next;
  logic               w_sig_next;
  logic               w_busy_next;
  logic               w_aborted_next;
  logic               w_abort;

`ifdef SIG_PULSE_ABORT_EN
  assign w_abort = abort;
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  assign gnt  = r_gnt;
  assign done = r_done;
  assign sig  = r_sig;
  assign busy = r_busy;

  // Zero-length requests are never eligible; search starts just after the last owner.
  always_comb begin : arb_c
    int unsigned idx;
    idx        = 0;
    w_elig     = '0;
    w_any      = 1'b0;
    w_pick     = r_rr_ptr;
    w_pick_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
    end
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && w_elig[PTR_W'(idx)]) begin
        w_any      = 1'b1;
        w_pick     = PTR_W'(idx);
        w_pick_len = req_len[idx*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin : next_state_c
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_DRIVE;
      S_DRIVE: if (w_abort || (r_cnt == LEN_W'(1))) w_state_next = S_GAP;
      S_GAP:   if (r_gap == '0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin : output_c
    w_owner_next   = (r_state == S_IDLE) ? w_pick : r_owner;
    w_gnt_next     = '0;
    w_done_next    = '0;
    w_aborted_next = 1'b0;
    w_sig_next     = (w_state_next == S_DRIVE);
    w_busy_next    = (w_state_next != S_IDLE);
    if (w_state_next == S_DRIVE) w_gnt_next[w_owner_next] = 1'b1;
    if ((r_state == S_DRIVE) && (w_state_next == S_GAP)) begin
      w_done_next[r_owner] = 1'b1;
      w_aborted_next       = w_abort;
    end
  end

  always_ff @(posedge clk) begin : datapath_reg
    if (reset) begin
      r_owner  <= '0;
      r_rr_ptr <= PTR_W'(NUM_REQ - 1);
      r_cnt    <= '0;
      r_gap    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner  <= w_pick;
            r_rr_ptr <= w_pick;
            r_cnt    <= w_pick_len;
          end
        end
        S_DRIVE: begin
          r_cnt <= r_cnt - LEN_W'(1);
          if (w_state_next == S_GAP) r_gap <= GAP_W'(GAP_CYCLES - 1);
        end
        S_GAP: begin
          if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin : output_reg
    if (reset) begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_sig     <= 1'b0;
      r_busy    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_next;
      r_done    <= w_done_next;
      r_sig     <= w_sig_next;
      r_busy    <= w_busy_next;
      r_aborted <= w_aborted_next;
    end
  end

endmodule

// File: tb/tb_sig_pulse_arbiter.sv
// Directed bench for sig_pulse_arbiter: per-cycle expected outputs are queued from the
// documented pulse timeline and compared against the DUT on every negative clock edge.
module tb_sig_pulse_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned GAP_CYCLES = 2;

  typedef struct packed {
    logic               sig;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic               busy;
    logic               aborted;
  } obs_t;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     sig;
  logic                     busy;
  logic                     abort;
  logic                     aborted;

  obs_t  sb[$];
  int    n_vec;
  int    n_err;
  string cur_tag;

  sig_pulse_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LEN_W      (LEN_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
`ifdef SIG_PULSE_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .gnt     (gnt),
    .done    (done),
    .sig     (sig),
    .busy    (busy)
  );

`ifndef SIG_PULSE_ABORT_EN
  assign aborted = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_REQ-1:0] onehot(input int unsigned o);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[o] = 1'b1;
    return v;
  endfunction

  task automatic push_idle(input int unsigned n);
    obs_t e;
    e = '0;
    for (int unsigned i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Expected cycles t+1 .. t+len high, then the gap with done in its first cycle.
  task automatic push_pulse(input int unsigned o, input int unsigned len);
    obs_t e;
    for (int unsigned i = 0; i < len; i++) begin
      e = '0; e.sig = 1'b1; e.gnt = onehot(o); e.busy = 1'b1;
      sb.push_back(e);
    end
    for (int unsigned i = 0; i < GAP_CYCLES; i++) begin
      e = '0; e.busy = 1'b1;
      if (i == 0) e.done = onehot(o);
      sb.push_back(e);
    end
  endtask

  task automatic set_len(input int unsigned i, input int unsigned v);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic check();
    obs_t e;
    obs_t o;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard underflow, observed output with no expectation", cur_tag);
      return;
    end
    e = sb.pop_front();
    o = {sig, gnt, done, busy, aborted};
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed sig=%b gnt=%b done=%b busy=%b aborted=%b, expected sig=%b gnt=%b done=%b busy=%b aborted=%b",
             cur_tag, o.sig, o.gnt, o.done, o.busy, o.aborted, e.sig, e.gnt, e.done, e.busy, e.aborted);
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check();
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    abort   = 1'b0;

    cur_tag = "reset";
    push_idle(2);
    run(2);
    reset = 1'b0;

    cur_tag = "single";
    req = 4'b0010; set_len(1, 3);
    push_pulse(1, 3); push_idle(2);
    run(1);
    req = '0;
    run(6);

    cur_tag = "rr_reset";
    reset = 1'b1;
    push_idle(1);
    run(1);
    reset = 1'b0;

    // All requesters held with len 1: order 0,1,2,3,0 with one IDLE cycle between.
    cur_tag = "round_robin";
    req = 4'b1111;
    for (int unsigned i = 0; i < NUM_REQ; i++) set_len(i, 1);
    push_pulse(0, 1); push_idle(1);
    push_pulse(1, 1); push_idle(1);
    push_pulse(2, 1); push_idle(1);
    push_pulse(3, 1); push_idle(1);
    push_pulse(0, 1); push_idle(1);
    run(20);
    req = '0;
    push_idle(2);
    run(2);

    cur_tag = "zero_len";
    req = 4'b0101; set_len(0, 0); set_len(2, 2);
    push_pulse(2, 2); push_idle(4);
    run(1);
    req = 4'b0001;
    run(7);
    req = '0;

    cur_tag = "latch";
    req = 4'b0100; set_len(2, 5);
    push_pulse(2, 5); push_idle(2);
    run(1);
    req = '0; set_len(2, 1);
    run(8);

    // Reset in DRIVE cycle 10 of a 200-cycle pulse; pointer must restart so 0 wins over 1.
    cur_tag = "reset_mid";
    req = 4'b0001; set_len(0, 200);
    for (int unsigned i = 0; i < 10; i++) sb.push_back({1'b1, onehot(0), 4'b0000, 1'b1, 1'b0});
    run(1);
    req = '0;
    run(9);
    reset = 1'b1;
    push_idle(1);
    run(1);
    reset = 1'b0;
    cur_tag = "post_reset";
    req = 4'b0011; set_len(0, 1); set_len(1, 1);
    push_pulse(0, 1); push_idle(1); push_pulse(1, 1); push_idle(2);
    run(1);
    req = 4'b0010;
    run(4);
    req = '0;
    run(4);

    cur_tag = "max_len_b2b";
    req = 4'b0100; set_len(2, 255);
    push_pulse(2, 255); push_idle(1); push_pulse(2, 255); push_idle(2);
    run(259);
    req = '0;
    run(258);

`ifdef SIG_PULSE_ABORT_EN
    cur_tag = "abort";
    abort = 1'b1;
    push_idle(1);
    run(1);
    abort = 1'b0;
    req = 4'b1000; set_len(3, 10);
    for (int unsigned i = 0; i < 4; i++) sb.push_back({1'b1, onehot(3), 4'b0000, 1'b1, 1'b0});
    sb.push_back({1'b0, 4'b0000, onehot(3), 1'b1, 1'b1});
    for (int unsigned i = 1; i < GAP_CYCLES; i++) sb.push_back({1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0});
    push_idle(2);
    run(1);
    req = '0;
    run(3);
    abort = 1'b1;
    run(1);
    run(1);
    abort = 1'b0;
    run(GAP_CYCLES - 2 + 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
